// File: rtl/mm_ebab_responder.sv
// mm_ebab bus slave: word RAM at BASE_ADDR, answered with a one-cycle ack pulse.
// Optional wait states are compiled in when MM_RESP_WAIT_EN is defined.
module mm_ebab_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 27,
    parameter int DEPTH       = 1024,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    read_en,
    input  logic                    write_en,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    ack,
    output logic [DATA_WIDTH-1:0]   read_data
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] BASE_X  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] LIMIT_X = (ADDR_WIDTH+1)'(BASE_ADDR + DEPTH);

    if ((DATA_WIDTH % 8) != 0 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_STATES < 0) begin : g_bad_cfg
        $error("mm_ebab_responder: illegal parameter combination");
    end

`ifdef MM_RESP_WAIT_EN
    localparam int CNT_RAW = $clog2(WAIT_STATES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WAIT_STATES);
    logic [CNT_W-1:0] cnt;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state;

    logic [ADDR_WIDTH-1:0]   addr_p0;
    logic [LANES-1:0]        be_p0;
    logic [DATA_WIDTH-1:0]   wdata_p0;
    logic                    is_wr_p0;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req;
    logic                    commit;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    assign req = read_en | write_en;

`ifdef MM_RESP_WAIT_EN
    assign commit = (state == S_WAIT) && (cnt == '0);
`else
    assign commit = (state == S_WAIT);
`endif

    assign in_range = ({1'b0, addr_p0} >= BASE_X) && ({1'b0, addr_p0} < LIMIT_X);
    assign idx      = IDX_W'(addr_p0 - ADDR_WIDTH'(BASE_ADDR));

    // Stage p0: request capture; only IDLE samples, so later input changes are ignored
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            addr_p0  <= addr;
            be_p0    <= byte_en;
            wdata_p0 <= write_data;
            is_wr_p0 <= write_en;
        end
    end

    // Stage p1: access at the last WAIT edge; the FSM is back in IDLE under reset so no write commits
    always_ff @(posedge clk) begin
        if (commit && is_wr_p0 && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_p0[i]) begin
                    mem[idx][8*i +: 8] <= wdata_p0[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ack       <= 1'b0;
            read_data <= '0;
`ifdef MM_RESP_WAIT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        state <= S_WAIT;
`ifdef MM_RESP_WAIT_EN
                        cnt   <= W_LOAD;
`endif
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        state <= S_ACK;
                        ack   <= 1'b1;
                        if (!is_wr_p0) begin
                            read_data <= in_range ? mem[idx] : '1;
                        end
                    end
`ifdef MM_RESP_WAIT_EN
                    else begin
                        cnt <= cnt - 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    ack   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_ebab_responder.sv
// Bench for mm_ebab_responder: directed cases plus random traffic against a word-array model.
module tb_mm_ebab_responder;

    localparam int BASE  = 256;
    localparam int DEPTH = 1024;
    localparam int NW    = 16;
`ifdef MM_RESP_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] addr;
    logic [1:0]  byte_en;
    logic        read_en;
    logic        write_en;
    logic [15:0] write_data;
    logic        ack;
    logic [15:0] read_data;

    mm_ebab_responder #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (27),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .byte_en   (byte_en),
        .read_en   (read_en),
        .write_en  (write_en),
        .write_data(write_data),
        .ack       (ack),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] model_mem [NW];
    logic [15:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in_range(input int a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    task automatic model_apply(input bit rd, input bit wr, input int a,
                               input logic [1:0] be, input logic [15:0] d);
        if (wr) begin
            if (model_in_range(a)) begin
                for (int b = 0; b < 2; b++) begin
                    if (be[b]) model_mem[a-BASE][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else if (rd) begin
            exp_rd = model_in_range(a) ? model_mem[a-BASE] : 16'hFFFF;
        end
    endtask

    // Entered and left at a negedge; the next posedge samples the request.
    task automatic do_req(input string tag, input bit rd, input bit wr, input int a,
                          input logic [1:0] be, input logic [15:0] d, output int ack_cyc);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        addr       = 27'(a);
        byte_en    = be;
        write_data = d;
        read_en    = rd;
        write_en   = wr;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) seen = 1'b1;
            else if (n == 1) begin
                addr       = 27'($urandom);
                write_data = 16'($urandom);
                byte_en    = 2'($urandom);
            end
        end
        ack_cyc = cycle;
        check({tag, "_latency"}, n, 2 + W);
        read_en  = 1'b0;
        write_en = 1'b0;
        if (seen) begin
            model_apply(rd, wr, a, be, d);
            check({tag, "_rdata"}, read_data, exp_rd);
            @(negedge clk);
            check({tag, "_ack_width"}, ack, 1'b0);
        end
    endtask

    initial begin
        int c, c_prev, a, r;
        bit rd, wr, any_ack;
        logic [1:0] be;

        reset = 1'b1; read_en = 1'b0; write_en = 1'b0;
        addr = '0; byte_en = '0; write_data = '0;
        repeat (2) @(negedge clk);
        check("reset_ack", ack, 1'b0);
        check("reset_rdata", read_data, 16'h0000);
        reset = 1'b0;
        exp_rd = 16'h0000;
        @(negedge clk);

        for (int i = 0; i < NW; i++) do_req("init_wr", 1'b0, 1'b1, BASE + i, 2'b11, 16'($urandom), c);

        do_req("wr_beef", 1'b0, 1'b1, BASE + 5, 2'b11, 16'hBEEF, c);
        do_req("rd_beef", 1'b1, 1'b0, BASE + 5, 2'b00, 16'h0000, c);
        check("rd_beef_const", read_data, 16'hBEEF);
        do_req("wr_lane0", 1'b0, 1'b1, BASE + 5, 2'b01, 16'h1234, c);
        do_req("rd_lane0", 1'b1, 1'b0, BASE + 5, 2'b10, 16'h0000, c);
        check("rd_lane0_const", read_data, 16'hBE34);

        do_req("wr_oor_hi", 1'b0, 1'b1, BASE + DEPTH, 2'b11, 16'h5A5A, c);
        do_req("rd_idx0", 1'b1, 1'b0, BASE, 2'b11, 16'h0000, c);
        do_req("rd_oor_lo", 1'b1, 1'b0, BASE - 1, 2'b11, 16'h0000, c);
        check("rd_oor_lo_const", read_data, 16'hFFFF);

        do_req("rd_wr_both", 1'b1, 1'b1, BASE + 3, 2'b11, 16'hC3C3, c);
        do_req("rd_both_back", 1'b1, 1'b0, BASE + 3, 2'b00, 16'h0000, c);
        check("rd_both_const", read_data, 16'hC3C3);
        do_req("wr_be0", 1'b0, 1'b1, BASE + 4, 2'b00, 16'h0000, c);
        do_req("rd_be0", 1'b1, 1'b0, BASE + 4, 2'b11, 16'h0000, c);

        do_req("b2b_rd", 1'b1, 1'b0, BASE + 1, 2'b11, 16'h0000, c_prev);
        for (int i = 0; i < 4; i++) begin
            do_req("b2b_rd", 1'b1, 1'b0, BASE + 2 + i, 2'b11, 16'h0000, c);
            check("b2b_period", c - c_prev, W + 3);
            c_prev = c;
        end

        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            wr = (r < 4) || (r == 8);
            rd = (r >= 4);
            be = 2'($urandom);
            if ($urandom_range(0, 9) < 8) a = BASE + $urandom_range(0, NW - 1);
            else begin
                case ($urandom_range(0, 3))
                    0: a = BASE - 1;
                    1: a = BASE + DEPTH;
                    2: a = 0;
                    default: a = BASE + DEPTH + NW / 2;
                endcase
            end
            do_req("rand", rd, wr, a, be, 16'($urandom), c);
        end

        do_req("wr_aaaa", 1'b0, 1'b1, BASE + 7, 2'b11, 16'hAAAA, c);
        do_req("rd_pre_rst", 1'b1, 1'b0, BASE + 5, 2'b11, 16'h0000, c);
        addr = 27'(BASE + 7); write_data = 16'h0F0F; byte_en = 2'b11; write_en = 1'b1;
        @(negedge clk);
        if (W > 0) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_ack", ack, 1'b0);
        check("midrst_rdata", read_data, 16'h0000);
        exp_rd = 16'h0000;
        @(negedge clk);
        write_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (ack !== 1'b0) any_ack = 1'b1;
        end
        check("midrst_no_ack", any_ack, 1'b0);
        do_req("rd_after_rst", 1'b1, 1'b0, BASE + 7, 2'b11, 16'h0000, c);
        check("rd_after_rst_const", read_data, 16'hAAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_ebab_responder.md
# mm_ebab_responder

Slave-side responder for the team's `mm_ebab` memory-mapped bus. It answers read and write requests from a bus master, such as `mm_cntrlr`, with a one-cycle `ack` pulse. Requests are served from an internal word RAM mapped at a fixed base address. It sits in the `sys_clk` domain and backs DMG-side scratch memory and register windows without routing traffic through QSys.

## Interface
Parameters:
- `DATA_WIDTH`, 16, bus data width; must be a multiple of 8.
- `ADDR_WIDTH`, 27, bus word-address width.
- `DEPTH`, 1024, number of RAM words; must be a power of two.
- `BASE_ADDR`, 0, first word address decoded by this block.
- `WAIT_STATES`, 2, extra cycles inserted before `ack`. Only used when `MM_RESP_WAIT_EN` is defined.

Ports:
- `clk`, in, 1, bus clock (`sys_clk`).
- `reset`, in, 1, asynchronous, active-high reset.
- `addr`, in, `ADDR_WIDTH`, word address.
- `byte_en`, in, `DATA_WIDTH/8`, byte lanes; bit i controls `[8i+7:8i]`.
- `read_en`, in, 1, read request; held by the master until `ack`.
- `write_en`, in, 1, write request; held by the master until `ack`.
- `write_data`, in, `DATA_WIDTH`, write data; held with `write_en`.
- `ack`, out, 1, one-cycle completion pulse.
- `read_data`, out, `DATA_WIDTH`, read result; valid in the `ack` cycle and held until the next read completes.

## Operation
- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE:** on `read_en | write_en`, latch `addr`, `byte_en`, `write_data` and the op type. Load the wait counter with W, then go to WAIT.
  - W = `WAIT_STATES` when `MM_RESP_WAIT_EN` is defined, otherwise 0.
- **WAIT:** decrement the counter each cycle. At 0, perform the access and go to ACK. When W = 0, WAIT lasts exactly one cycle.
- **ACK:** `ack` = 1 for exactly this cycle, then return to IDLE. Request inputs are not sampled while in ACK.
- Address decode: the address is in range when `BASE_ADDR <= addr < BASE_ADDR+DEPTH`. The RAM index is `addr - BASE_ADDR`, truncated to `$clog2(DEPTH)` bits.
- Writes update only the lanes with their `byte_en` bit set. Out-of-range writes are dropped but still acknowledged.
- Reads return the RAM word with all lanes, regardless of `byte_en`. Out-of-range reads return all ones (`16'hFFFF`).
- If `read_en` and `write_en` are both high, the request is treated as a write and `read_data` is unchanged.
- A write with `byte_en` = 0 is acknowledged and leaves the RAM unchanged.
- The latched request values are used for the whole transaction. Input changes after acceptance are ignored.

## Timing
- Request first sampled high at edge 0:
  - the RAM write commits, or `read_data` is registered, at edge 1+W;
  - `ack` is high for the cycle after edge 1+W and low after edge 2+W.
- Back-to-back requests: the master drops its request after seeing `ack`. A new request held in the first IDLE cycle is accepted at that edge, so the minimum period is W+3 cycles.
- Reset values: `ack` = 0, `read_data` = 0, state = IDLE, wait counter = 0.
- RAM contents are undefined at power-up and preserved across `reset`.
- Reset mid-transaction:
  - the transaction is aborted with no `ack`;
  - a write that has not reached its commit edge is not performed;
  - after reset deasserts, a still-asserted request is accepted as new.
- No combinational paths from inputs to outputs.

## Configuration
- `MM_RESP_WAIT_EN` defined: `WAIT_STATES` is honoured. The counter is `$clog2(WAIT_STATES+1)` bits (at least 1), and read latency to `ack` is `WAIT_STATES`+2 cycles.
- `MM_RESP_WAIT_EN` undefined:
  - the counter logic is compiled out and `WAIT_STATES` is ignored;
  - latency is fixed at 2 cycles, from request sampled to `ack` visible.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> `ack` = 0 and `read_data` = 0 immediately; FSM in IDLE.
- **Write/read, W = 0 (macro undefined):**
  - write `addr` = 5, `write_data` = `16'hBEEF`, `byte_en` = `2'b11` -> `ack` at cycle 2;
  - read `addr` = 5 -> `read_data` = `16'hBEEF` with `ack` at cycle 2.
- **Byte lanes:** write `16'h1234` with `byte_en` = `2'b01` over `16'hBEEF` at the same address -> readback `16'hBE34`.
- **Out of range:** `BASE_ADDR` = 256, `DEPTH` = 1024.
  - write `addr` = 1280 -> `ack` issued and RAM unchanged;
  - read `addr` = 255 -> `16'hFFFF`.
- **Wait states:** `MM_RESP_WAIT_EN` defined, `WAIT_STATES` = 3 -> `ack` exactly 5 cycles after request sampling. Back-to-back reads complete every 6 cycles, each `ack` exactly 1 cycle wide.
- **Reset mid-write:** W = 3; assert `reset` at cycle 2 of a write of `16'h0F0F` to `addr` = 7, where `addr` = 7 previously held `16'hAAAA`.
  - no `ack` is issued;
  - after reset, a read of `addr` = 7 returns `16'hAAAA`.
